dmem_responder: RTL

- Data-memory responder on the far end of the load/store unit's memory interface; the load/store unit is the initiator.
- Accepts active-low chip-select requests carrying a write flag, byte mask and lane-positioned write data, and services them after a programmable number of wait states.
- Returns the full read word, a one-cycle acknowledge and an address-range error.
- Byte and halfword extraction and sign extension stay in the load/store unit; this block works on whole words with byte-lane write enables.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store unit: whole-word array with byte-lane write enables.
// Latency: request accepted in IDLE, LATENCY wait cycles, then a one-cycle DONE with ack (LATENCY+2 cycles per access).
// Backpressure: stall is high while a request is being accepted or is pending; inputs are ignored until DONE has passed.
//
// Ports: clk/rst (sync, active-high); cs (active-low request), wr (1=read, 0=write), Mem_Addr (byte address),
//        mask (byte-lane write enables), wdata (lane-positioned store data);
//        Mem_rd (registered read word), stall (combinational), ack (completion pulse), err (out-of-range, valid with ack).
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [31:0] Mem_Addr,
    input  logic [3:0]  mask,
    input  logic [31:0] wdata,
    output logic [31:0] Mem_rd,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0]  CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;

    // Request captured at acceptance; used for the access when LATENCY > 0.
    logic        req_rd;
    logic [29:0] req_idx;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc_fire;
    logic        acc_rd;
    logic        acc_oor;
    logic [29:0] acc_idx;
    logic [3:0]  acc_mask;
    logic [31:0] acc_wdata;
    logic        err_q;

    // Byte offset bits never influence the access.
    logic        addr_lsb_unused;
    assign addr_lsb_unused = ^Mem_Addr[1:0];

    // With zero wait states the access happens on the acceptance edge, so it
    // must use the live inputs; otherwise it uses the captured request.
    always_comb begin
        acc_fire = 1'b0;
        if (state == S_IDLE && !cs && LATENCY == 0) acc_fire = 1'b1;
        if (state == S_WAIT && cnt == 3'd0)         acc_fire = 1'b1;
    end

    assign acc_rd    = (state == S_IDLE) ? wr             : req_rd;
    assign acc_idx   = (state == S_IDLE) ? Mem_Addr[31:2] : req_idx;
    assign acc_mask  = (state == S_IDLE) ? mask           : req_mask;
    assign acc_wdata = (state == S_IDLE) ? wdata          : req_wdata;
    assign acc_oor   = (acc_idx >= DEPTH_W);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!cs) state_nxt = (LATENCY == 0) ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == 3'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        stall = (state == S_IDLE && !cs) || (state == S_WAIT);
        ack   = (state == S_DONE);
        err   = (state == S_DONE) && err_q;
    end

    // Wait counter, request capture and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 3'd0;
            Mem_rd    <= 32'd0;
            err_q     <= 1'b0;
            req_rd    <= 1'b0;
            req_idx   <= 30'd0;
            req_mask  <= 4'd0;
            req_wdata <= 32'd0;
        end else begin
            if (state == S_IDLE && !cs) begin
                cnt       <= CNT_LOAD;
                req_rd    <= wr;
                req_idx   <= Mem_Addr[31:2];
                req_mask  <= mask;
                req_wdata <= wdata;
            end else if (state == S_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (acc_fire) begin
                err_q <= acc_oor;
                if (acc_oor)     Mem_rd <= 32'd0;
                else if (acc_rd) Mem_rd <= mem[acc_idx[AW-1:0]];
            end
        end
    end

    // Array is not cleared by reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && acc_fire && !acc_oor && !acc_rd) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) mem[acc_idx[AW-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule
